pass_sequencer: RTL and testbench

Top-level scheduler for the training datapath. Sequences one shared MAC unit through three passes in order: forward layer 0 (F0), forward layer 1 (F1), then backward (B). Repeats the full F0→F1→B sequence for a programmed number of epochs. Issues one step request per datapath step over a valid/ready handshake, and tells the datapath which pass is active.

---
 rtl/pass_sequencer.sv | 135 +++++++++++++
 tb/tb_pass_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pass_sequencer.sv
// Scheduler that walks one shared MAC unit through F0 -> F1 -> B for a programmed
// number of epochs. Optional macro PASS_SEQ_INFER_ONLY_EN adds infer_i to skip the B pass.
module pass_sequencer #(
  parameter int N0      = 4,
  parameter int N1      = 4,
  parameter int NB      = 8,
  parameter int CNT_W   = 4,
  parameter int EPOCH_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               init_i,
  input  logic               abort_i,
  input  logic [EPOCH_W-1:0] epochs_i,
  input  logic               mac_ready_i,
`ifdef PASS_SEQ_INFER_ONLY_EN
  input  logic               infer_i,
`endif
  output logic               mac_valid_o,
  output logic [CNT_W-1:0]   step_idx_o,
  output logic               f0_pass_o,
  output logic               f1_pass_o,
  output logic               b_pass_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [EPOCH_W-1:0] epoch_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_F0, S_F1, S_B, S_DONE} state_e;

  localparam logic [CNT_W-1:0] LAST0 = CNT_W'(N0 - 1);
  localparam logic [CNT_W-1:0] LAST1 = CNT_W'(N1 - 1);
  localparam logic [CNT_W-1:0] LASTB = CNT_W'(NB - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W-1:0] epochs_q, epochs_d;
  logic [EPOCH_W-1:0] epoch_inc;
  logic               in_pass, accept, last_step, epoch_end, skip_b;

`ifdef PASS_SEQ_INFER_ONLY_EN
  logic infer_q, infer_d;
  assign skip_b = infer_q;
`else
  assign skip_b = 1'b0;
`endif

  assign in_pass   = (state_q == S_F0) || (state_q == S_F1) || (state_q == S_B);
  assign accept    = in_pass && en_i && mac_ready_i;
  assign last_step = ((state_q == S_F0) && (step_q == LAST0)) ||
                     ((state_q == S_F1) && (step_q == LAST1)) ||
                     ((state_q == S_B)  && (step_q == LASTB));
  assign epoch_inc = epoch_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    epoch_d   = epoch_q;
    epochs_d  = epochs_q;
    epoch_end = 1'b0;
`ifdef PASS_SEQ_INFER_ONLY_EN
    infer_d   = infer_q;
`endif
    if (en_i) begin
      case (state_q)
        S_IDLE: begin
          if (init_i) begin
            // A zero epoch request still runs one epoch.
            epochs_d = (epochs_i == '0) ? EPOCH_W'(1) : epochs_i;
            epoch_d  = '0;
            step_d   = '0;
            state_d  = S_F0;
`ifdef PASS_SEQ_INFER_ONLY_EN
            infer_d  = infer_i;
`endif
          end
        end
        S_DONE: state_d = S_IDLE;
        default: begin
          if (abort_i) begin
            state_d = S_IDLE;
            step_d  = '0;
          end else if (accept) begin
            if (!last_step) begin
              step_d = step_q + 1'b1;
            end else begin
              step_d = '0;
              case (state_q)
                S_F0:    state_d = S_F1;
                S_F1:    if (skip_b) epoch_end = 1'b1; else state_d = S_B;
                default: epoch_end = 1'b1;
              endcase
            end
            if (epoch_end) begin
              epoch_d = epoch_inc;
              state_d = (epoch_inc == epochs_q) ? S_DONE : S_F0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      epoch_q  <= '0;
      epochs_q <= '0;
`ifdef PASS_SEQ_INFER_ONLY_EN
      infer_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      epoch_q  <= epoch_d;
      epochs_q <= epochs_d;
`ifdef PASS_SEQ_INFER_ONLY_EN
      infer_q  <= infer_d;
`endif
    end
  end

  assign mac_valid_o = en_i && in_pass;
  assign step_idx_o  = step_q;
  assign f0_pass_o   = (state_q == S_F0);
  assign f1_pass_o   = (state_q == S_F1);
  assign b_pass_o    = (state_q == S_B);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign epoch_cnt_o = epoch_q;

endmodule

// File: tb/tb_pass_sequencer.sv
// Bench for pass_sequencer: a vector table, directed multi-cycle runs and random
// stimulus, all checked against a step-list reference model.
module tb_pass_sequencer;
  localparam int N0 = 4, N1 = 4, NB = 8, CNT_W = 4, EPOCH_W = 8;
  localparam int S = N0 + N1 + NB;

  typedef logic [17:0] obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i = 1'b1, en_i = 1'b0, init_i = 1'b0, abort_i = 1'b0, mac_ready_i = 1'b0;
  logic [EPOCH_W-1:0] epochs_i = '0;
  logic               mac_valid_o, f0_pass_o, f1_pass_o, b_pass_o, busy_o, done_o;
  logic [CNT_W-1:0]   step_idx_o;
  logic [EPOCH_W-1:0] epoch_cnt_o;
`ifdef PASS_SEQ_INFER_ONLY_EN
  logic infer_i = 1'b0;
`endif

  pass_sequencer #(.N0(N0), .N1(N1), .NB(NB), .CNT_W(CNT_W), .EPOCH_W(EPOCH_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .init_i(init_i), .abort_i(abort_i),
    .epochs_i(epochs_i), .mac_ready_i(mac_ready_i),
`ifdef PASS_SEQ_INFER_ONLY_EN
    .infer_i(infer_i),
`endif
    .mac_valid_o(mac_valid_o), .step_idx_o(step_idx_o), .f0_pass_o(f0_pass_o),
    .f1_pass_o(f1_pass_o), .b_pass_o(b_pass_o), .busy_o(busy_o), .done_o(done_o),
    .epoch_cnt_o(epoch_cnt_o)
  );

  obs_t dut_obs;
  assign dut_obs = {mac_valid_o, step_idx_o, f0_pass_o, f1_pass_o, b_pass_o, busy_o, done_o, epoch_cnt_o};

  int n_vec = 0, n_err = 0;
  int s_done, s_acc;

  // Reference model: a run is a flat list of E*S steps; ptr counts accepted steps.
  int m_st = 0;   // 0 idle, 1 running, 2 done
  int m_ptr = 0, m_E = 0, m_epoch = 0;

  function automatic obs_t ex(bit v, int idx, logic [2:0] f, bit busy, bit done, int ep);
    return {v, 4'(idx), f, busy, done, 8'(ep)};
  endfunction

  function automatic obs_t model_exp(bit en);
    int r;
    case (m_st)
      1: begin
        r = m_ptr % S;
        if (r < N0)           return ex(en, r, 3'b100, 1, 0, m_ptr / S);
        else if (r < N0 + N1) return ex(en, r - N0, 3'b010, 1, 0, m_ptr / S);
        else                  return ex(en, r - N0 - N1, 3'b001, 1, 0, m_ptr / S);
      end
      2:       return ex(0, 0, 3'b000, 1, 1, m_E);
      default: return ex(0, 0, 3'b000, 0, 0, m_epoch);
    endcase
  endfunction

  task automatic model_update(bit en, bit init, bit abort, bit ready, int epochs);
    if (!en) return;
    case (m_st)
      0: if (init) begin
        m_E = (epochs == 0) ? 1 : epochs;
        m_ptr = 0; m_epoch = 0; m_st = 1;
      end
      1: if (abort) begin
        m_epoch = m_ptr / S; m_st = 0;
      end else if (ready) begin
        m_ptr++;
        if (m_ptr == m_E * S) begin m_st = 2; m_epoch = m_E; end
      end
      default: begin m_st = 0; m_epoch = m_E; end
    endcase
  endtask

  task automatic check(string name, obs_t exp);
    n_vec++;
    if (dut_obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, dut_obs, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(bit en, bit init, bit abort, bit ready, int epochs, string name);
    en_i = en; init_i = init; abort_i = abort; mac_ready_i = ready; epochs_i = 8'(epochs);
    @(negedge clk);
    s_done = int'(done_o);
    s_acc  = int'(mac_valid_o && mac_ready_i);
    check(name, model_exp(en));
    @(posedge clk);
    model_update(en, init, abort, ready, epochs);
    #1;
  endtask

  task automatic run_dir(input int epochs, input int stall_ptr, input int stall_len,
                         input int abort_ptr, input int en_ptr, input int en_len,
                         output int cyc, output int dones, output int accs);
    int st, el, guard;
    bit en, rdy, ab;
    tick(1, 1, 0, 0, epochs, "init");
    cyc = 0; dones = 0; accs = 0; st = stall_len; el = en_len; guard = 0;
    while (m_st != 0 && guard < 2000) begin
      en = 1; rdy = 1; ab = 0;
      if (m_st == 1 && m_ptr == stall_ptr && st > 0) begin rdy = 0; st--; end
      if (m_st == 1 && m_ptr == en_ptr && el > 0) begin en = 0; el--; end
      if (m_st == 1 && m_ptr == abort_ptr) ab = 1;
      tick(en, 0, ab, rdy, 0, "run");
      cyc++; dones += s_done; accs += s_acc; guard++;
    end
    if (guard >= 2000) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: got %0d cycles required fewer than 2000", guard);
    end
  endtask

  typedef struct {
    bit en, init, abort, ready;
    int epochs;
    obs_t exp;
  } vec_t;

  initial begin
    vec_t tbl[13];
    int cyc, dones, accs;

    tbl[0]  = '{1, 0, 0, 0, 0, ex(0, 0, 3'b000, 0, 0, 0)};
    tbl[1]  = '{1, 1, 0, 0, 0, ex(0, 0, 3'b000, 0, 0, 0)};
    tbl[2]  = '{1, 0, 0, 1, 0, ex(1, 0, 3'b100, 1, 0, 0)};
    tbl[3]  = '{1, 0, 0, 1, 0, ex(1, 1, 3'b100, 1, 0, 0)};
    tbl[4]  = '{1, 0, 0, 0, 0, ex(1, 2, 3'b100, 1, 0, 0)};
    tbl[5]  = '{1, 0, 0, 0, 0, ex(1, 2, 3'b100, 1, 0, 0)};
    tbl[6]  = '{0, 0, 0, 1, 0, ex(0, 2, 3'b100, 1, 0, 0)};
    tbl[7]  = '{1, 0, 0, 1, 0, ex(1, 2, 3'b100, 1, 0, 0)};
    tbl[8]  = '{1, 0, 0, 1, 0, ex(1, 3, 3'b100, 1, 0, 0)};
    tbl[9]  = '{1, 0, 0, 1, 0, ex(1, 0, 3'b010, 1, 0, 0)};
    tbl[10] = '{1, 0, 1, 1, 0, ex(1, 1, 3'b010, 1, 0, 0)};
    tbl[11] = '{1, 1, 1, 0, 1, ex(0, 0, 3'b000, 0, 0, 0)};
    tbl[12] = '{1, 0, 0, 1, 0, ex(1, 0, 3'b100, 1, 0, 0)};

    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      en_i = tbl[i].en; init_i = tbl[i].init; abort_i = tbl[i].abort;
      mac_ready_i = tbl[i].ready; epochs_i = 8'(tbl[i].epochs);
      @(negedge clk);
      check($sformatf("table[%0d]", i), tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset while mid-F0: outputs clear before the next edge.
    rst_i = 1'b1;
    #1 check("async_reset_idle", ex(0, 0, 3'b000, 0, 0, 0));
    @(posedge clk); #1 rst_i = 1'b0;
    m_st = 0; m_ptr = 0; m_epoch = 0; m_E = 0;

    run_dir(1, -1, 0, -1, -1, 0, cyc, dones, accs);
    check_int("e1_cycles", cyc, S + 1);
    check_int("e1_done_pulses", dones, 1);
    check_int("e1_accepts", accs, S);
    tick(1, 0, 0, 1, 0, "e1_idle_after");

    run_dir(3, -1, 0, -1, -1, 0, cyc, dones, accs);
    check_int("e3_cycles", cyc, 3 * S + 1);
    check_int("e3_done_pulses", dones, 1);
    check_int("e3_accepts", accs, 3 * S);

    run_dir(0, -1, 0, -1, -1, 0, cyc, dones, accs);
    check_int("e0_cycles", cyc, S + 1);
    check_int("e0_done_pulses", dones, 1);

    run_dir(1, N0 + 2, 5, -1, -1, 0, cyc, dones, accs);
    check_int("stall_cycles", cyc, S + 1 + 5);

    run_dir(3, -1, 0, S + N0 + N1 + 5, -1, 0, cyc, dones, accs);
    check_int("abort_cycles", cyc, S + N0 + N1 + 5 + 1);
    check_int("abort_no_done", dones, 0);
    tick(1, 0, 0, 1, 0, "abort_idle_epoch1");

    run_dir(1, -1, 0, -1, 2, 3, cyc, dones, accs);
    check_int("enlow_cycles", cyc, S + 1 + 3);

    // Reset in the middle of F1.
    tick(1, 1, 0, 0, 2, "rst_run_init");
    for (int i = 0; i < N0 + 1; i++) tick(1, 0, 0, 1, 0, "rst_run_step");
    rst_i = 1'b1;
    #1 check("async_reset_f1", ex(0, 0, 3'b000, 0, 0, 0));
    @(posedge clk); #1 rst_i = 1'b0;
    m_st = 0; m_ptr = 0; m_epoch = 0; m_E = 0;
    tick(1, 0, 0, 1, 0, "after_reset_idle");

    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(7) != 0), ($urandom_range(7) == 0), ($urandom_range(29) == 0),
           ($urandom_range(3) != 0), int'($urandom_range(3)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish required finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
